// File: rtl/kronos_types.sv
// rtl/kronos_types.sv - shared access-size encodings and lane helpers for write-back
package kronos_types;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mask_e;

  // Misaligned half/word accesses simply truncate the low address bits.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr);
    case (size)
      BYTE:    lane_mask = 4'b0001 << addr;
      HALF:    lane_mask = 4'b0011 << {addr[1], 1'b0};
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      BYTE:    lane_data = {4{data[7:0]}};
      HALF:    lane_data = {2{data[15:0]}};
      default: lane_data = data;
    endcase
  endfunction

endpackage

// File: rtl/kronos_wb_align.sv
// rtl/kronos_wb_align.sv - load lane extraction and sign/zero extension
module kronos_wb_align
  import kronos_types::*;
(
  input  logic [31:0] rd_data,
  input  logic [1:0]  addr,
  input  logic [1:0]  mask,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr)
      2'd0:    byte_lane = rd_data[7:0];
      2'd1:    byte_lane = rd_data[15:8];
      2'd2:    byte_lane = rd_data[23:16];
      default: byte_lane = rd_data[31:24];
    endcase
    half_lane = addr[1] ? rd_data[31:16] : rd_data[15:0];

    case (mask)
      BYTE:    data = {{24{sign & byte_lane[7]}}, byte_lane};
      HALF:    data = {{16{sign & half_lane[15]}}, half_lane};
      default: data = rd_data;
    endcase
  end

endmodule

// File: rtl/kronos_wb.sv
// rtl/kronos_wb.sv - write-back stage: register retire and single-outstanding data bus access
module kronos_wb
  import kronos_types::*;
(
  input  logic        clk,
  input  logic        rstz,
  input  logic        execute_vld,
  output logic        execute_rdy,
  input  logic [31:0] result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  input  logic        rd_write,
  input  logic        load,
  input  logic        store,
  input  logic [1:0]  mask,
  input  logic        sign,
  output logic [31:0] data_addr,
  output logic [31:0] data_wr_data,
  output logic [3:0]  data_mask,
  output logic        data_wr_en,
  output logic        data_req,
  input  logic        data_ack,
  input  logic [31:0] data_rd_data,
  output logic [31:0] regwr_data,
  output logic [4:0]  regwr_sel,
  output logic        regwr_en
);

  typedef enum logic {STEADY, MEM} state_e;

  state_e      state;
  logic [4:0]  rd_q;
  logic        rd_write_q;
  logic        load_q;
  logic        sign_q;
  logic [1:0]  mask_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] load_data;

  // Memory ops are accepted on the ack cycle; the execute stage holds them until then.
  assign execute_rdy = rstz & ((state == STEADY) ? (execute_vld & ~(load | store)) : data_ack);

  kronos_wb_align u_align (
    .rd_data (data_rd_data),
    .addr    (addr_lo_q),
    .mask    (mask_q),
    .sign    (sign_q),
    .data    (load_data)
  );

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state        <= STEADY;
      data_addr    <= '0;
      data_wr_data <= '0;
      data_mask    <= '0;
      data_wr_en   <= 1'b0;
      data_req     <= 1'b0;
      regwr_data   <= '0;
      regwr_sel    <= '0;
      regwr_en     <= 1'b0;
      rd_q         <= '0;
      rd_write_q   <= 1'b0;
      load_q       <= 1'b0;
      sign_q       <= 1'b0;
      mask_q       <= '0;
      addr_lo_q    <= '0;
    end else begin
      regwr_en <= 1'b0;
      case (state)
        STEADY: begin
          if (execute_vld) begin
            if (!load && !store) begin
              regwr_en   <= rd_write;
              regwr_sel  <= rd;
              regwr_data <= result;
            end else begin
              state        <= MEM;
              data_req     <= 1'b1;
              data_addr    <= {result[31:2], 2'b00};
              data_wr_en   <= store;
              data_mask    <= lane_mask(mask, result[1:0]);
              data_wr_data <= lane_data(mask, store_data);
              rd_q         <= rd;
              rd_write_q   <= rd_write;
              load_q       <= load;
              sign_q       <= sign;
              mask_q       <= mask;
              addr_lo_q    <= result[1:0];
            end
          end
        end
        MEM: begin
          if (data_ack) begin
            state    <= STEADY;
            data_req <= 1'b0;
            if (load_q) begin
              regwr_en   <= rd_write_q;
              regwr_sel  <= rd_q;
              regwr_data <= load_data;
            end
          end
        end
        default: state <= STEADY;
      endcase
    end
  end

endmodule
